// File: rtl/dmem_responder.sv
// Data-memory responder for the ME-stage memory interface.
// Word-addressed synchronous RAM behind a fixed-latency request/ready
// handshake. Each accepted request completes with a one-cycle ready pulse,
// and stall holds the ME stage while an access is outstanding.
module dmem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req,
    input  logic        wmem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic enter_resp;

    // Request captured at acceptance; used while the access is in flight.
    logic                 lat_wmem;
    logic [ADDR_BITS-1:0] lat_word;
    logic                 lat_mis;
    logic [31:0]          lat_wdata;

    // Operands of the access that completes this cycle. With LATENCY=1 the
    // access completes straight out of IDLE, so the live inputs are used.
    logic                 cur_wmem;
    logic [ADDR_BITS-1:0] cur_word;
    logic                 cur_mis;
    logic [31:0]          cur_wdata;

    logic [ADDR_BITS-1:0] in_word;
    logic                 in_mis;

    logic [31:0] mem [DEPTH];

    // Upper byte-address bits are ignored, so addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_BITS+2];

    assign in_word = addr[ADDR_BITS+1:2];
    assign in_mis  = (addr[1:0] != 2'b00);
    assign stall   = req & ~ready;

    // Select live or latched request fields for the completing access.
    always_comb begin
        cur_wmem  = lat_wmem;
        cur_word  = lat_word;
        cur_mis   = lat_mis;
        cur_wdata = lat_wdata;
        if (state == IDLE) begin
            cur_wmem  = wmem;
            cur_word  = in_word;
            cur_mis   = in_mis;
            cur_wdata = wdata;
        end
    end

    // Next-state logic: accept in IDLE, count down latency in WAIT, pulse in RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_next = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request fields on acceptance.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            lat_wmem  <= 1'b0;
            lat_word  <= '0;
            lat_mis   <= 1'b0;
            lat_wdata <= 32'd0;
        end else if (state == IDLE && req) begin
            lat_wmem  <= wmem;
            lat_word  <= in_word;
            lat_mis   <= in_mis;
            lat_wdata <= wdata;
        end
    end

    // RAM write on entry to RESP; reset abandons the access, contents persist.
    always_ff @(posedge clock) begin
        if (resetn && enter_resp && cur_wmem && !cur_mis) begin
            mem[cur_word] <= cur_wdata;
        end
    end

    // Response registers: ready/err pulse, rdata updated only by loads and errors.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rdata <= 32'd0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= enter_resp;
            err   <= enter_resp && cur_mis;
            if (enter_resp) begin
                if (cur_mis) begin
                    rdata <= 32'd0;
                end else if (!cur_wmem) begin
                    rdata <= mem[cur_word];
                end
            end
        end
    end

endmodule
